sample_frame_loader: RTL and testbench
======================================

Name: sample_frame_loader

Overview:
Upstream stage of the peak finder. It accepts one frame of 32-bit float samples over an AXI-Stream slave and writes them into the sample BRAM (port A) at addresses 0..FRAME_LEN-1. It then pulses the peak finder's start, holds off new input until the peak finder reports done, and re-arms for the next frame. It also flags frames whose length does not match FRAME_LEN.

Parameters:
FRAME_LEN, 8192, samples per frame; must be at least 2 and at most 2^ADDR_W.
ADDR_W, 13, sample BRAM address width.
DATA_W, 32, sample width (IEEE-754 single).

Ports:
clk  in  1  system clock; the only clock.
rst  in  1  synchronous reset, active-high.
s_axis_tvalid  in  1  sample beat valid.
s_axis_tready  out  1  loader can accept a beat.
s_axis_tdata  in  DATA_W  sample.
s_axis_tlast  in  1  last beat of frame.
bram_clk  out  1  equals clk.
bram_we  out  1  sample BRAM write enable.
bram_addr  out  ADDR_W  sample BRAM address.
bram_din  out  DATA_W  sample BRAM write data.
pf_start  out  1  one-cycle start pulse to peak finder.
pf_done  in  1  peak finder finished (one-cycle pulse).
busy  out  1  high in every state except RECV.
frame_count  out  16  completed frames; wraps at 16 bits.
err_short  out  1  sticky: a frame ended early (tlast before FRAME_LEN beats).
err_long  out  1  sticky: a frame ran past FRAME_LEN beats without tlast.
clear_err  in  1  clears err_short and err_long.

Behaviour:
- Reset:
  - state=RECV, wr_ptr=0.
  - bram_we, bram_addr, bram_din, pf_start, busy, frame_count, err_short and err_long are all 0.
  - s_axis_tready is 0 while rst is high.
- Handshake:
  - A beat is accepted when s_axis_tvalid && s_axis_tready.
  - s_axis_tready is 1 only in RECV and DRAIN.
- BRAM outputs:
  - bram_we, bram_addr and bram_din are registered.
  - An accepted beat drives a write on the next cycle, at address wr_ptr.
  - bram_we is 0 on any cycle with no write.
- RECV:
  - On each accepted beat, write the sample and increment wr_ptr.
  - Beat with wr_ptr==FRAME_LEN-1 and tlast=1: go to START.
  - Beat with wr_ptr==FRAME_LEN-1 and tlast=0: set err_long and go to DRAIN.
  - Beat with tlast=1 and wr_ptr<FRAME_LEN-1: set err_short, then follow the optional feature.
- DRAIN:
  - Accept and discard beats; no BRAM writes.
  - When the tlast beat is accepted, go to START.
- FILL (feature enabled only):
  - s_axis_tready=0.
  - Write 0 to wr_ptr..FRAME_LEN-1, one address per cycle, then go to START.
- START:
  - pf_start=1 for exactly this one cycle, then go to WAIT_DONE.
  - The final sample write lands in the same cycle, so the BRAM is complete before the peak finder's first fetch.
- WAIT_DONE:
  - s_axis_tready=0.
  - On pf_done: frame_count+1, wr_ptr=0, go to RECV.
  - No timeout.
- pf_done in any state other than WAIT_DONE is ignored.
- wr_ptr is ADDR_W+1 bits wide, so FRAME_LEN=2^ADDR_W does not wrap early.
- If clear_err and an error set occur in the same cycle, the set wins.
- A mid-frame rst returns the block to RECV with wr_ptr=0. Samples already in the BRAM are not cleared. No pf_start is issued.
- Latency: pf_start rises exactly 1 cycle after the final accepted beat (RECV) or the tlast beat (DRAIN).

Optional Feature:
LOADER_ZERO_FILL_EN:
- Defined: a short frame enters FILL, zero-pads the rest of the frame, then STARTs the peak finder as normal.
- Undefined: a short frame is aborted. wr_ptr=0, the FSM stays in RECV, and no pf_start is issued. frame_count is unchanged. err_short is set in both builds.

Test Plan:
- Full frame: 8192 beats with data=index, tlast on beat 8191 -> 8192 writes to addr 0..8191 with din=addr; pf_start pulse 1 cycle after the last beat; tready=0 until pf_done, then frame_count=1.
- Backpressure: random tvalid gaps over a full frame -> write sequence is identical, with no duplicate or skipped addresses.
- Short frame: tlast on beat 99 -> err_short=1.
  - With LOADER_ZERO_FILL_EN: addr 100..8191 written 0, then pf_start.
  - Without: no pf_start; the next full frame starts at addr 0.
- Long frame: 8200 beats, tlast on the last -> err_long=1; only addr 0..8191 written; beats 8192..8199 dropped; one pf_start after beat 8199.
- Clear vs set: assert clear_err in the same cycle err_short would set -> err_short stays 1; clear_err the next cycle -> 0.
- Reset mid-frame: rst after 500 beats, then a full frame -> no pf_start before the new frame completes; writes restart at addr 0; frame_count=1 after pf_done.

Source files
------------

// File: rtl/sample_frame_loader_if.sv
// AXI-Stream sample channel between the upstream source and the frame loader.
interface sample_frame_loader_if #(
    parameter int unsigned DATA_W = 32
);
    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic              tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/sample_frame_loader.sv
// Frame loader: writes one AXI-Stream frame into the sample BRAM, starts the
// peak finder, waits for its done pulse and re-arms. Flags short/long frames.
// Build option LOADER_ZERO_FILL_EN: zero-pad short frames and still start the
// peak finder (otherwise a short frame is aborted).
module sample_frame_loader #(
    parameter int unsigned FRAME_LEN = 8192,
    parameter int unsigned ADDR_W    = 13,
    parameter int unsigned DATA_W    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    sample_frame_loader_if.slave  s_axis,
    output logic                  bram_clk,
    output logic                  bram_we,
    output logic [ADDR_W-1:0]     bram_addr,
    output logic [DATA_W-1:0]     bram_din,
    output logic                  pf_start,
    input  logic                  pf_done,
    output logic                  busy,
    output logic [15:0]           frame_count,
    output logic                  err_short,
    output logic                  err_long,
    input  logic                  clear_err
);

    // One extra pointer bit so FRAME_LEN == 2**ADDR_W does not wrap early.
    localparam int unsigned       PTR_W    = ADDR_W + 1;
    localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(FRAME_LEN - 1);

    localparam logic [2:0] S_RECV  = 3'd0;
    localparam logic [2:0] S_DRAIN = 3'd1;
`ifdef LOADER_ZERO_FILL_EN
    localparam logic [2:0] S_FILL  = 3'd2;
`endif
    localparam logic [2:0] S_START = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic              bram_we_q, bram_we_d;
    logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
    logic [DATA_W-1:0] bram_din_q, bram_din_d;
    logic              pf_start_q, pf_start_d;
    logic              busy_q, busy_d;
    logic [15:0]       frame_count_q, frame_count_d;
    logic              err_short_q, err_short_d;
    logic              err_long_q, err_long_d;
    logic              set_short, set_long;
    logic              accept;

    // Ready is a pure decode of the receiving states, forced low during reset.
    assign s_axis.tready = !rst && (state_q == S_RECV || state_q == S_DRAIN);
    assign accept        = s_axis.tvalid && s_axis.tready;

    // Next-state, BRAM write and status computation.
    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        bram_we_d     = 1'b0;
        bram_addr_d   = bram_addr_q;
        bram_din_d    = bram_din_q;
        frame_count_d = frame_count_q;
        set_short     = 1'b0;
        set_long      = 1'b0;

        case (state_q)
            S_RECV: begin
                if (accept) begin
                    bram_we_d   = 1'b1;
                    bram_addr_d = wr_ptr_q[ADDR_W-1:0];
                    bram_din_d  = s_axis.tdata;
                    wr_ptr_d    = wr_ptr_q + PTR_W'(1);
                    if (wr_ptr_q == LAST_PTR) begin
                        if (s_axis.tlast) begin
                            state_d = S_START;
                        end else begin
                            set_long = 1'b1;
                            state_d  = S_DRAIN;
                        end
                    end else if (s_axis.tlast) begin
                        set_short = 1'b1;
`ifdef LOADER_ZERO_FILL_EN
                        state_d   = S_FILL;
`else
                        wr_ptr_d  = '0;
`endif
                    end
                end
            end
            S_DRAIN: begin
                if (accept && s_axis.tlast) begin
                    state_d = S_START;
                end
            end
`ifdef LOADER_ZERO_FILL_EN
            S_FILL: begin
                bram_we_d   = 1'b1;
                bram_addr_d = wr_ptr_q[ADDR_W-1:0];
                bram_din_d  = '0;
                wr_ptr_d    = wr_ptr_q + PTR_W'(1);
                if (wr_ptr_q == LAST_PTR) begin
                    state_d = S_START;
                end
            end
`endif
            S_START: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (pf_done) begin
                    frame_count_d = frame_count_q + 16'd1;
                    wr_ptr_d      = '0;
                    state_d       = S_RECV;
                end
            end
            default: begin
                state_d  = S_RECV;
                wr_ptr_d = '0;
            end
        endcase

        pf_start_d  = (state_d == S_START);
        busy_d      = (state_d != S_RECV);
        err_short_d = (err_short_q && !clear_err) || set_short;
        err_long_d  = (err_long_q && !clear_err) || set_long;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_RECV;
            wr_ptr_q      <= '0;
            bram_we_q     <= 1'b0;
            bram_addr_q   <= '0;
            bram_din_q    <= '0;
            pf_start_q    <= 1'b0;
            busy_q        <= 1'b0;
            frame_count_q <= '0;
            err_short_q   <= 1'b0;
            err_long_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            bram_we_q     <= bram_we_d;
            bram_addr_q   <= bram_addr_d;
            bram_din_q    <= bram_din_d;
            pf_start_q    <= pf_start_d;
            busy_q        <= busy_d;
            frame_count_q <= frame_count_d;
            err_short_q   <= err_short_d;
            err_long_q    <= err_long_d;
        end
    end

    assign bram_clk    = clk;
    assign bram_we     = bram_we_q;
    assign bram_addr   = bram_addr_q;
    assign bram_din    = bram_din_q;
    assign pf_start    = pf_start_q;
    assign busy        = busy_q;
    assign frame_count = frame_count_q;
    assign err_short   = err_short_q;
    assign err_long    = err_long_q;

endmodule

// File: tb/tb_sample_frame_loader.sv
// Scoreboard bench for sample_frame_loader: random stimulus, frame-level model.
module tb_sample_frame_loader;

    localparam int unsigned FL = 8192;
    localparam int unsigned AW = 13;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          bram_clk, bram_we, pf_start, pf_done, busy;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_din;
    logic [15:0]   frame_count;
    logic          err_short, err_long, clear_err;

    sample_frame_loader_if #(.DATA_W(DW)) axis ();

    sample_frame_loader #(.FRAME_LEN(FL), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .s_axis(axis),
        .bram_clk(bram_clk), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_din(bram_din), .pf_start(pf_start), .pf_done(pf_done),
        .busy(busy), .frame_count(frame_count), .err_short(err_short),
        .err_long(err_long), .clear_err(clear_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    wr_t exp_wr[$];
    int  exp_start[$];
    int  start_cnt = 0;
    int  starts_target = 0;

    // Reference model: position within the current frame plus error/frame state.
    int  m_ptr = 0;
    bit  m_drop = 0;
    bit  m_err_short = 0;
    bit  m_err_long = 0;
    int  m_frames = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic abort(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out", name);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "bench stopped on timeout");
    endtask

    // Monitor: pop expected writes and start pulses whenever the DUT presents them.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (bram_we === 1'b1) begin
                if (exp_wr.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL wr_unexpected: got write addr %0d data %0h, none expected", bram_addr, bram_din);
                end else begin
                    wr_t w;
                    w = exp_wr.pop_front();
                    check("wr_addr", 64'(bram_addr), 64'(w.addr));
                    check("wr_data", 64'(bram_din), 64'(w.data));
                end
            end
            if (pf_start === 1'b1) begin
                if (exp_start.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL pf_start_unexpected: got pulse at cycle %0d, none expected", cyc);
                end else begin
                    check("pf_start_cycle", 64'(cyc), 64'(exp_start.pop_front()));
                    check("writes_done_at_start", 64'(exp_wr.size()), 64'd0);
                end
                start_cnt++;
            end
        end
    end

    // Model update for one beat accepted on the coming clock edge.
    task automatic model_accept(input logic [31:0] d, input bit l, input bit clr);
        bit s_short = 0;
        bit s_long  = 0;
        if (!m_drop) begin
            exp_wr.push_back('{m_ptr, d});
            if (m_ptr == FL - 1) begin
                if (l) begin
                    exp_start.push_back(cyc + 1);
                    starts_target++;
                end else begin
                    s_long = 1;
                    m_drop = 1;
                end
                m_ptr = 0;
            end else if (l) begin
                s_short = 1;
`ifdef LOADER_ZERO_FILL_EN
                for (int a = m_ptr + 1; a < FL; a++) exp_wr.push_back('{a, 32'd0});
                exp_start.push_back(cyc + FL - m_ptr);
                starts_target++;
`endif
                m_ptr = 0;
            end else begin
                m_ptr++;
            end
        end else if (l) begin
            m_drop = 0;
            exp_start.push_back(cyc + 1);
            starts_target++;
        end
        if (clr) begin
            m_err_short = 0;
            m_err_long  = 0;
        end
        m_err_short |= s_short;
        m_err_long  |= s_long;
    endtask

    // Drive one beat (entered and left on a falling edge) with optional idle gaps.
    task automatic send_beat(input logic [31:0] d, input bit l, input int gap, input bit clr, input bit spur);
        int n = 0;
        while (gap > 0 && int'($urandom_range(99)) < gap) begin
            axis.tvalid = 1'b0;
            @(negedge clk);
        end
        axis.tvalid = 1'b1;
        axis.tdata  = d;
        axis.tlast  = l;
        while (axis.tready !== 1'b1) begin
            @(negedge clk);
            n++;
            if (n > 1000) abort("tready_wait");
        end
        clear_err = clr;
        pf_done   = spur;
        model_accept(d, l, clr);
        @(negedge clk);
        clear_err   = 1'b0;
        pf_done     = 1'b0;
        axis.tvalid = 1'b0;
        axis.tlast  = 1'b0;
    endtask

    task automatic send_frame(input int nbeats, input int last_idx, input int gap,
                              input bit idx_data, input bit clr_last, input int spur_at);
        for (int i = 0; i < nbeats; i++) begin
            logic [31:0] d;
            d = idx_data ? 32'(i) : 32'($urandom);
            send_beat(d, i == last_idx, gap, clr_last && (i == last_idx), i == spur_at);
        end
    endtask

    // Act as the peak finder: wait for the start, hold a few cycles, pulse done.
    task automatic wait_done();
        int n = 0;
        int hold;
        while (start_cnt < starts_target) begin
            @(negedge clk);
            n++;
            if (n > 20000) abort("pf_start_wait");
        end
        hold = int'($urandom_range(4, 1));
        for (int i = 0; i < hold; i++) begin
            check("tready_while_busy", 64'(axis.tready), 64'd0);
            check("busy_while_waiting", 64'(busy), 64'd1);
            @(negedge clk);
        end
        pf_done = 1'b1;
        m_frames++;
        @(negedge clk);
        pf_done = 1'b0;
        check("frame_count", 64'(frame_count), 64'(16'(m_frames)));
        check("busy_after_done", 64'(busy), 64'd0);
        check("tready_after_done", 64'(axis.tready), 64'd1);
    endtask

    task automatic check_errs();
        check("err_short", 64'(err_short), 64'(m_err_short));
        check("err_long", 64'(err_long), 64'(m_err_long));
    endtask

    task automatic do_reset();
        axis.tvalid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("tready_in_reset", 64'(axis.tready), 64'd0);
        @(negedge clk);
        check("tready_in_reset", 64'(axis.tready), 64'd0);
        check("rst_bram_we", 64'(bram_we), 64'd0);
        check("rst_bram_addr", 64'(bram_addr), 64'd0);
        check("rst_bram_din", 64'(bram_din), 64'd0);
        check("rst_pf_start", 64'(pf_start), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_frame_count", 64'(frame_count), 64'd0);
        check("rst_err_short", 64'(err_short), 64'd0);
        check("rst_err_long", 64'(err_long), 64'd0);
        check("pending_writes_at_reset", 64'(exp_wr.size()), 64'd0);
        rst = 1'b0;
        m_ptr = 0;
        m_drop = 0;
        m_err_short = 0;
        m_err_long = 0;
        m_frames = 0;
        @(posedge clk);
        #1;
        check("bram_clk_high", 64'(bram_clk), 64'd1);
        @(negedge clk);
        check("bram_clk_low", 64'(bram_clk), 64'd0);
        check("tready_after_reset", 64'(axis.tready), 64'd1);
    endtask

    initial begin
        rst = 1'b1;
        axis.tvalid = 1'b0;
        axis.tdata = '0;
        axis.tlast = 1'b0;
        pf_done = 1'b0;
        clear_err = 1'b0;
        do_reset();

        // Full frame, data = index, no gaps.
        send_frame(FL, FL - 1, 0, 1'b1, 1'b0, -1);
        wait_done();
        check_errs();

        // Full frame with random valid gaps and random data.
        send_frame(FL, FL - 1, 30, 1'b0, 1'b0, -1);
        wait_done();
        check_errs();

        // Short frame; clear_err coincides with the set, plus a stray pf_done.
        send_frame(100, 99, 0, 1'b0, 1'b1, 10);
`ifdef LOADER_ZERO_FILL_EN
        wait_done();
`endif
        repeat (5) @(negedge clk);
        check_errs();
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        m_err_short = 0;
        m_err_long = 0;
        check_errs();

        // Long frame: beats past FRAME_LEN are dropped until tlast.
        send_frame(FL + 8, FL + 7, 10, 1'b0, 1'b0, -1);
        wait_done();
        check_errs();

        // Reset mid-frame, then a clean full frame.
        send_frame(500, -1, 0, 1'b0, 1'b0, -1);
        @(negedge clk);
        do_reset();
        send_frame(FL, FL - 1, 5, 1'b1, 1'b0, -1);
        wait_done();
        check_errs();

        repeat (10) @(negedge clk);
        check("leftover_writes", 64'(exp_wr.size()), 64'd0);
        check("leftover_starts", 64'(exp_start.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
